// File: rtl/chart_sequencer.sv
// chart_sequencer: walks the song chart ROM and offers timed arrow spawns over valid/ready.
// Define CHART_LOOP_EN to restart the chart from entry 0 instead of stopping in DONE.
module chart_sequencer #(
  parameter int CHART_LEN = 64,
  parameter int ADDR_W = 6,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic              frame_i,
  input  logic              start_i,
  input  logic              pause_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic              spawn_valid_o,
  input  logic              spawn_ready_i,
  output logic [3:0]        spawn_arrows_o,
  output logic [3:0]        spawn_timing_o,
  output logic [ADDR_W-1:0] step_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int FCW = $clog2(FRAMES_PER_STEP + 1);
`ifdef CHART_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, HOLD, OFFER, PAUSED, DONE} state_t;
  state_t state, state_n, ret, ret_n;
  logic [ADDR_W-1:0] addr, addr_n, step, step_n;
  logic [FCW-1:0] fcnt, fcnt_n;
  logic [3:0] scnt, scnt_n, arrows, arrows_n, timing, timing_n;
  logic pend, pend_n, done, done_n, consume, fin, tick, last;
  assign tick = frame_i && fcnt == FCW'(FRAMES_PER_STEP - 1);
  assign last = addr == ADDR_W'(CHART_LEN - 1);
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state <= IDLE;
      ret <= IDLE;
      addr <= '0;
      step <= '0;
      fcnt <= '0;
      scnt <= '0;
      arrows <= '0;
      timing <= '0;
      pend <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      addr <= addr_n;
      step <= step_n;
      fcnt <= fcnt_n;
      scnt <= scnt_n;
      arrows <= arrows_n;
      timing <= timing_n;
      pend <= pend_n;
      done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    ret_n = ret;
    addr_n = addr;
    step_n = step;
    fcnt_n = fcnt;
    scnt_n = scnt;
    arrows_n = arrows;
    timing_n = timing;
    pend_n = pend;
    done_n = 1'b0;
    consume = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE, DONE: if (start_i) begin
        state_n = FETCH;
        addr_n = '0;
        step_n = '0;
      end
      FETCH: if (pause_i) begin
        state_n = PAUSED;
        ret_n = FETCH;
      end else state_n = WAIT_DATA;
      WAIT_DATA: if (pause_i) begin
        state_n = PAUSED;
        ret_n = WAIT_DATA;
      end else if (rom_data_i == 8'hFF) fin = 1'b1;
      else begin
        arrows_n = rom_data_i[3:0];
        timing_n = rom_data_i[7:4];
        scnt_n = rom_data_i[7:4] == 4'd0 ? 4'd1 : rom_data_i[7:4];
        fcnt_n = '0;
        state_n = HOLD;
      end
      HOLD: if (pause_i) begin
        state_n = PAUSED;
        ret_n = HOLD;
      end else if (frame_i) begin
        fcnt_n = tick ? '0 : fcnt + FCW'(1);
        if (tick) begin
          scnt_n = scnt - 4'd1;
          if (scnt == 4'd1) begin
            if (arrows != 4'd0) state_n = OFFER;
            else consume = 1'b1;
          end
        end
      end
      OFFER: begin
        pend_n = pend | pause_i;
        consume = spawn_ready_i;
      end
      PAUSED: if (pause_i) state_n = ret;
      default: state_n = IDLE;
    endcase
    // A pause requested during the offer takes effect once the entry is consumed
    if (consume) begin
      step_n = &step ? step : step + ADDR_W'(1);
      if (last) fin = 1'b1;
      else begin
        addr_n = addr + ADDR_W'(1);
        state_n = pend_n ? PAUSED : FETCH;
        ret_n = FETCH;
      end
      pend_n = 1'b0;
    end
    if (fin) begin
      done_n = 1'b1;
      if (LOOP) begin
        state_n = FETCH;
        addr_n = '0;
        step_n = '0;
      end else state_n = DONE;
    end
  end
  assign rom_addr_o = addr;
  assign spawn_valid_o = state == OFFER;
  assign spawn_arrows_o = arrows;
  assign spawn_timing_o = timing;
  assign step_o = step;
  assign busy_o = state != IDLE && state != DONE;
  assign done_o = done;
endmodule

// File: doc/chart_sequencer.md
Name: chart_sequencer

Overview:
Controller that steps through the song chart ROM and schedules arrow spawns for the arrow logic at the correct musical time. It counts frame pulses into steps, holds each chart entry until its delay expires, then offers it over a valid/ready handshake. It sits between the chart ROM and arrow_logic in the pixel-clock domain, and provides start, pause and end-of-song sequencing.

Parameters:
CHART_LEN, 64, number of chart ROM entries (2..256)
ADDR_W, 6, ROM address width; must satisfy 2**ADDR_W >= CHART_LEN
FRAMES_PER_STEP, 8, frame_i pulses per chart step (1..255)

Ports:
clk_pix  in  1  pixel clock; only clock
rst_pix  in  1  reset; synchronous, active-high
frame_i  in  1  one-cycle pulse at the start of vertical blanking
start_i  in  1  one-cycle pulse; start or restart the song
pause_i  in  1  one-cycle pulse; toggle pause
rom_addr_o  out  ADDR_W  chart ROM address
rom_data_i  in  8  ROM word {timing[7:4], arrows[3:0]}; valid 1 cycle after address
spawn_valid_o  out  1  spawn entry offered
spawn_ready_i  in  1  arrow logic accepts the entry
spawn_arrows_o  out  4  lanes {right,down,up,left}
spawn_timing_o  out  4  timing field of the offered entry
step_o  out  ADDR_W  count of entries consumed in this run
busy_o  out  1  high in every state except IDLE and DONE
done_o  out  1  one-cycle pulse at song end

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0.
- States and transitions:
  - IDLE: start_i → FETCH with addr=0 and step_o=0.
  - FETCH (1 cycle): drive rom_addr_o=addr → WAIT_DATA.
  - WAIT_DATA (1 cycle): latch rom_data_i.
    - Entry {F,F} is the end marker → DONE.
    - Otherwise load step_cnt = timing (timing 0 is treated as 1), clear frame_cnt → HOLD.
  - HOLD: on each frame_i, frame_cnt++. When frame_cnt reaches FRAMES_PER_STEP-1 on a frame_i, clear frame_cnt and decrement step_cnt.
    - The cycle step_cnt reaches 0: if arrows≠0 → OFFER; else (rest entry) consume it (see below).
  - OFFER: spawn_valid_o=1 with arrows and timing stable until spawn_valid_o && spawn_ready_i. In that cycle consume the entry.
  - Consume: step_o++. If addr==CHART_LEN-1 → DONE; else addr++ → FETCH.
  - DONE: done_o pulses for exactly the entry cycle; start_i → FETCH with addr=0 and step_o=0.
- Handshake:
  - spawn_valid_o is registered and never drops without acceptance.
  - It is low for at least 2 cycles between offers (FETCH and WAIT_DATA).
  - spawn_ready_i is ignored when spawn_valid_o is low.
  - The delay of an entry starts counting only after the previous entry is consumed.
- Pause:
  - pause_i in FETCH, WAIT_DATA or HOLD → PAUSED, saving the return state. frame_cnt, step_cnt and addr are frozen, and frame_i is ignored.
  - pause_i in OFFER is deferred. PAUSED is entered instead of FETCH after the handshake, with FETCH saved as the return state.
  - pause_i in PAUSED → saved state.
  - pause_i in IDLE or DONE is ignored.
  - busy_o stays 1 while PAUSED.
- start_i while busy is ignored. start_i and pause_i in the same cycle in IDLE or DONE: start wins.
- rst_pix mid-operation: returns to IDLE within 1 cycle and drops spawn_valid_o regardless of spawn_ready_i.
- Arithmetic:
  - frame_cnt width is $clog2(FRAMES_PER_STEP+1).
  - step_cnt is 4 bits.
  - addr and step_o are ADDR_W bits, with no wrap except under the optional feature.
- Latency: start_i to first spawn_valid_o = 3 cycles + timing×FRAMES_PER_STEP frames.

Optional Feature:
CHART_LOOP_EN
- Defined: at the end marker or after consuming entry CHART_LEN-1, pulse done_o and go to FETCH with addr=0 and step_o=0. DONE is never entered and busy_o stays 1 until reset.
- Undefined: behaviour exactly as above; the song stops in DONE.

Test Plan:
- Reset, FRAMES_PER_STEP=2, ROM[0]=8'h21, ROM[1]=8'hFF, start_i, spawn_ready_i=1 → spawn_valid_o rises after the 4th frame_i, arrows=4'h1, timing=4'h2. Then done_o pulses once, busy_o=0, step_o=1.
- ROM[0]=8'h10 (rest), ROM[1]=8'h18 → no spawn for entry 0. One offer with arrows=4'h8 after 2 steps total. step_o=2 at end.
- spawn_ready_i held 0 for 50 cycles during OFFER → spawn_valid_o and data stay constant. The accept cycle increments step_o. Next rom_addr_o = previous addr+1.
- pause_i during HOLD, 10 frame_i pulses, then pause_i → spawn occurs exactly the remaining number of frames later than the unpaused run. pause_i during OFFER → handshake completes, then PAUSED with rom_addr_o held.
- ROM with no end marker, CHART_LEN=4, all 8'h1F → 4 spawns, then done_o. With CHART_LOOP_EN, a 5th spawn occurs from addr 0 and busy_o stays 1.
- rst_pix asserted with spawn_valid_o=1 → next cycle spawn_valid_o=0, busy_o=0, step_o=0. start_i while busy has no effect on addr.
